pll_lock_reset_seq: RTL and testbench

Reset and lock sequencer that consumes the PLL40_2F_CORE lock indication and drives that PLL's RESETB and BYPASS pins. It runs on the free-running reference clock that also feeds the PLL. It sequences PLL reset, then qualifies LOCK with a stability filter and a timeout, and retries a bounded number of times. It releases the system reset only after a stable lock, or falls back to bypass.

---
 rtl/pll_lock_reset_seq_if.sv | 23 ++
 rtl/pll_lock_reset_seq.sv | 169 ++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pll_lock_reset_seq_if.sv
// Signal bundle between the PLL lock/reset sequencer and its surroundings.
// The sequencer takes the slave view; the PLL/system side takes the master view.
interface pll_lock_reset_seq_if;
  logic       LOCK;
  logic       RESTART;
  logic       PLL_RESETB;
  logic       PLL_BYPASS;
  logic       SYS_RESETN;
  logic       LOCKED;
  logic       PLL_FAIL;
  logic       LOCK_LOST;
  logic [1:0] RETRY_CNT;

  modport master (
    output LOCK, RESTART,
    input  PLL_RESETB, PLL_BYPASS, SYS_RESETN, LOCKED, PLL_FAIL, LOCK_LOST, RETRY_CNT
  );

  modport slave (
    input  LOCK, RESTART,
    output PLL_RESETB, PLL_BYPASS, SYS_RESETN, LOCKED, PLL_FAIL, LOCK_LOST, RETRY_CNT
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies LOCK with a stability
// filter and timeout, retries a bounded number of times, then releases system reset or bypasses.
module pll_lock_reset_seq #(
  parameter int unsigned PLL_RESET_CYCLES    = 16,
  parameter int unsigned LOCK_FILTER_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned RST_RELEASE_CYCLES  = 8,
  parameter int unsigned CNT_W               = 16
) (
  input  logic                 REFERENCECLK,
  input  logic                 RESETB,
  pll_lock_reset_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_PLLRST   = 3'd0,
    ST_WAITLOCK = 3'd1,
    ST_FILTER   = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_RUN      = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RST_RELEASE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] filt_q, filt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [1:0]       retry_q, retry_d;
  logic             lock_lost_q, lock_lost_d;
  logic             lock_meta_q, lock_s_q;
  logic             pll_resetb_q, pll_resetb_d;
  logic             pll_bypass_q, pll_bypass_d;
  logic             sys_resetn_q, sys_resetn_d;
  logic             locked_q, locked_d;
  logic             pll_fail_q, pll_fail_d;
  logic             timeout;

  assign timeout = (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    filt_d      = filt_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;

    if (bus.RESTART) begin
      state_d     = ST_PLLRST;
      cnt_d       = '0;
      filt_d      = '0;
      tmo_d       = '0;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_PLLRST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAITLOCK;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAITLOCK, ST_FILTER: begin
          // Timeout wins over any lock event on the same edge.
          if (timeout) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 2'd1;
              state_d = ST_PLLRST;
              cnt_d   = '0;
            end else begin
              state_d = ST_FAIL;
            end
          end else if (state_q == ST_WAITLOCK) begin
            if (lock_s_q) begin
              state_d = ST_FILTER;
              filt_d  = '0;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end else if (!lock_s_q) begin
            state_d = ST_WAITLOCK;
          end else if (filt_q == FILT_LAST) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            filt_d = filt_q + 1'b1;
            tmo_d  = tmo_q + 1'b1;
          end
        end
        ST_SETTLE, ST_RUN: begin
          if (!lock_s_q) begin
            state_d     = ST_PLLRST;
            cnt_d       = '0;
            retry_d     = '0;
            lock_lost_d = 1'b1;
          end else if (state_q == ST_SETTLE) begin
            if (cnt_q == REL_LAST) begin
              state_d = ST_RUN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_PLLRST;
      endcase
    end
  end

  // Outputs are decoded from the next state so each pin is a plain flop.
  always_comb begin
    pll_resetb_d = !((state_d == ST_PLLRST) || (state_d == ST_FAIL));
    pll_bypass_d = (state_d == ST_FAIL);
    sys_resetn_d = (state_d == ST_RUN) || (state_d == ST_FAIL);
    locked_d     = (state_d == ST_RUN);
    pll_fail_d   = (state_d == ST_FAIL);
  end

  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q      <= ST_PLLRST;
      cnt_q        <= '0;
      filt_q       <= '0;
      tmo_q        <= '0;
      retry_q      <= '0;
      lock_lost_q  <= 1'b0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      pll_resetb_q <= 1'b0;
      pll_bypass_q <= 1'b0;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
      pll_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      filt_q       <= filt_d;
      tmo_q        <= tmo_d;
      retry_q      <= retry_d;
      lock_lost_q  <= lock_lost_d;
      lock_meta_q  <= bus.LOCK;
      lock_s_q     <= lock_meta_q;
      pll_resetb_q <= pll_resetb_d;
      pll_bypass_q <= pll_bypass_d;
      sys_resetn_q <= sys_resetn_d;
      locked_q     <= locked_d;
      pll_fail_q   <= pll_fail_d;
    end
  end

  assign bus.PLL_RESETB = pll_resetb_q;
  assign bus.PLL_BYPASS = pll_bypass_q;
  assign bus.SYS_RESETN = sys_resetn_q;
  assign bus.LOCKED     = locked_q;
  assign bus.PLL_FAIL   = pll_fail_q;
  assign bus.LOCK_LOST  = lock_lost_q;
  assign bus.RETRY_CNT  = retry_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with small parameters; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_pll_lock_reset_seq;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  pll_lock_reset_seq_if bus();

  pll_lock_reset_seq #(
    .PLL_RESET_CYCLES   (4),
    .LOCK_FILTER_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2),
    .RST_RELEASE_CYCLES (4),
    .CNT_W              (16)
  ) dut (
    .REFERENCECLK(clk),
    .RESETB      (rstb),
    .bus         (bus)
  );

  // {PLL_RESETB, PLL_BYPASS, SYS_RESETN, LOCKED, PLL_FAIL, LOCK_LOST, RETRY_CNT[1:0]}
  logic [7:0] outs;
  assign outs = {bus.PLL_RESETB, bus.PLL_BYPASS, bus.SYS_RESETN, bus.LOCKED,
                 bus.PLL_FAIL, bus.LOCK_LOST, bus.RETRY_CNT};

  int n_vec = 0;
  int n_err = 0;
  int e_cnt;
  int fall_edge;
  logic saw_sys;

  // Test 2 expectations per edge after reset release: {PLL_RESETB, RETRY_CNT, PLL_FAIL}
  int         t2_edge [12] = '{3, 4, 35, 36, 39, 40, 71, 72, 75, 76, 107, 108};
  logic [3:0] t2_exp  [12] = '{4'h0, 4'h8, 4'h8, 4'h2, 4'h2, 4'hA,
                               4'hA, 4'h4, 4'h4, 4'hC, 4'hC, 4'h5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("vec %0d %s: got %0h expected %0h ok", n_vec, tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    chk({tag, "_rst_vals"}, outs, 8'h00);
    @(negedge clk);
    rstb = 1'b1;
  endtask

  // PLL_RESETB low for three more edges, high on the fourth.
  task automatic check_prst(input string tag);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk($sformatf("%s_prstb_e%0d", tag, i), bus.PLL_RESETB, (i == 4));
    end
  endtask

  task automatic tick_mon();
    tick(1);
    e_cnt++;
    if (bus.SYS_RESETN || bus.LOCKED) saw_sys = 1'b1;
    if (!bus.PLL_RESETB && fall_edge == 0) fall_edge = e_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.LOCK    = 1'b0;
    bus.RESTART = 1'b0;

    // Test 1: happy path, LOCK raised 10 cycles after release.
    do_reset("t1");
    check_prst("t1");
    tick(6);
    bus.LOCK = 1'b1;
    tick(14);
    chk("t1_sysrst_before", bus.SYS_RESETN, 1'b0);
    tick(1);
    chk("t1_run", outs, 8'hB0);

    // Test 3: single-cycle LOCK drop in RUN.
    bus.LOCK = 1'b0;
    tick(1);
    bus.LOCK = 1'b1;
    chk("t3_run_hold1", outs, 8'hB0);
    tick(1);
    chk("t3_run_hold2", outs, 8'hB0);
    tick(1);
    chk("t3_drop", outs, 8'h04);
    check_prst("t3");
    tick(12);
    chk("t3_sysrst_before", bus.SYS_RESETN, 1'b0);
    tick(1);
    chk("t3_rerun", outs, 8'hB4);

    // Test 6: asynchronous reset in the middle of SETTLE.
    bus.LOCK = 1'b0;
    tick(1);
    bus.LOCK = 1'b1;
    tick(16);
    chk("t6_in_settle", outs, 8'h84);
    #2 rstb = 1'b0;
    #1 chk("t6_async_rst", outs, 8'h00);
    @(negedge clk);
    rstb = 1'b1;
    check_prst("t6");

    // Test 4: three 5-cycle LOCK glitches in WAITLOCK.
    bus.LOCK = 1'b0;
    do_reset("t4");
    check_prst("t4");
    e_cnt     = 4;
    fall_edge = 0;
    saw_sys   = 1'b0;
    for (int p = 0; p < 3; p++) begin
      bus.LOCK = 1'b1;
      repeat (5) tick_mon();
      bus.LOCK = 1'b0;
      repeat (3) tick_mon();
    end
    while (fall_edge == 0 && e_cnt < 80) tick_mon();
    chk("t4_no_settle", saw_sys, 1'b0);
    chk("t4_tmo_window", (fall_edge >= 36 && fall_edge <= 42), 1'b1);
    chk("t4_retry", bus.RETRY_CNT, 2'd1);

    // Test 2: LOCK never arrives; three attempts then FAIL.
    bus.LOCK = 1'b0;
    do_reset("t2");
    k = 0;
    for (int e = 1; e <= 108; e++) begin
      tick(1);
      if (e == t2_edge[k]) begin
        chk($sformatf("t2_e%0d", e), {bus.PLL_RESETB, bus.RETRY_CNT, bus.PLL_FAIL}, t2_exp[k]);
        if (k < 11) k++;
      end
    end
    chk("t2_fail_outs", outs, 8'h6A);
    tick(10);
    chk("t2_fail_hold", outs, 8'h6A);

    // Test 5: RESTART out of FAIL, then a normal lock.
    bus.RESTART = 1'b1;
    tick(1);
    bus.RESTART = 1'b0;
    chk("t5_restart", outs, 8'h00);
    check_prst("t5");
    tick(2);
    bus.LOCK = 1'b1;
    tick(14);
    chk("t5_sysrst_before", bus.SYS_RESETN, 1'b0);
    tick(1);
    chk("t5_run", outs, 8'hB0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
